// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_t : sequencer state encoding (2 bits)
//   cnt_width   : bit width needed to hold the larger of two cycle counts
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        POR_COUNT = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low button.
//   clk    : sampling clock
//   rst    : asynchronous active-high reset
//   btn_n  : raw asynchronous button, active-low
//   btn_db : debounced pressed level (1 = pressed)
// btn_db changes only after the synchronised input has disagreed with it
// for CYCLES consecutive cycles; any agreeing sample restarts the count.
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_db
);

    localparam int unsigned    CW   = cnt_width(CYCLES, 1);
    localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

    logic          btn_m;
    logic          btn_s;
    logic          pressed;
    logic [CW-1:0] cnt;

    assign pressed = ~btn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m  <= 1'b1;
            btn_s  <= 1'b1;
            btn_db <= 1'b0;
            cnt    <= '0;
        end else begin
            btn_m <= btn_n;
            btn_s <= btn_m;
            if (pressed == btn_db) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                btn_db <= pressed;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / reset sequencer: waits for PLL lock, counts a POR delay, then
// releases NUM_STAGES resets in order with STAGE_GAP cycles between them.
// Lock loss or a debounced button press returns to WAIT_LOCK.
//   clk       : PLL output clock
//   rst       : asynchronous active-high reset
//   locked    : PLL lock, asynchronous
//   btn_n     : user reset button, active-low, asynchronous
//   lost_clr  : synchronous pulse clearing lock_lost
//   rst_out   : per-stage reset, active-high, stage 0 released first
//   ready     : all stages released
//   lock_lost : sticky, set when lock drops outside WAIT_LOCK
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned POR_CYCLES      = 1023,
    parameter int unsigned STAGE_GAP       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  btn_n,
    input  logic                  lost_clr,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  lock_lost
);

    localparam int unsigned   CW       = cnt_width(POR_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [NUM_STAGES-1:0] rst_out_nxt;
    logic [NUM_STAGES-1:0] stage_shift;
    logic                  ready_nxt;
    logic                  lost_set;
    logic                  lock_m;
    logic                  lock_s;
    logic                  btn_db;
    logic                  abort;

    sync_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n),
        .btn_db (btn_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= locked;
            lock_s <= lock_m;
        end
    end

    // Releasing a stage shifts a zero in from the bottom, so the pattern is a
    // thermometer by construction; an all-zero result marks the final stage.
    assign stage_shift = rst_out << 1;
    assign abort       = ~lock_s | btn_db;
    assign lost_set    = ~lock_s & (state != WAIT_LOCK);

    // State register (outputs are registered alongside)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rst_out <= rst_out_nxt;
            ready   <= ready_nxt;
            if (lost_set) begin
                lock_lost <= 1'b1;
            end else if (lost_clr) begin
                lock_lost <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: begin
                if (lock_s && !btn_db) state_nxt = POR_COUNT;
            end
            POR_COUNT: begin
                if (abort)                 state_nxt = WAIT_LOCK;
                else if (cnt == POR_LAST)  state_nxt = (stage_shift == '0) ? RUN : RELEASE;
            end
            RELEASE: begin
                if (abort)                                       state_nxt = WAIT_LOCK;
                else if (cnt == GAP_LAST && stage_shift == '0)   state_nxt = RUN;
            end
            RUN: begin
                if (abort) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // Output / counter next values
    always_comb begin
        cnt_nxt     = '0;
        rst_out_nxt = rst_out;
        ready_nxt   = (state_nxt == RUN);
        if (state_nxt == WAIT_LOCK) begin
            rst_out_nxt = '1;
        end else if (state == POR_COUNT && state_nxt != POR_COUNT) begin
            rst_out_nxt = stage_shift;
        end else if (state == RELEASE && cnt == GAP_LAST) begin
            rst_out_nxt = stage_shift;
        end else if (state == POR_COUNT || state == RELEASE) begin
            cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        end
    end

endmodule
